// File: rtl/frac_mul_pkg.sv
// Shared types and helpers for the signed-fraction sequential multiplier.
// State enum, counter-width function, saturation constant helper.
package frac_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MAX_W  = 32;
  localparam int MAX_PW = 2 * MAX_W - 1;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  // Largest positive Q1.(2w-2) value: 0 followed by 2w-2 ones.
  function automatic logic [MAX_PW-1:0] sat_const(input int w);
    logic [MAX_PW-1:0] one;
    one = MAX_PW'(1);
    return (one << (2 * w - 2)) - one;
  endfunction

endpackage

// File: rtl/frac_mul_addsub.sv
// (W+1)-bit combinational adder/subtractor used by the add-and-shift loop.
// Ports: a, b operands; sub selects a-b; y result.
module frac_mul_addsub #(
  parameter int W = 4
) (
  input  logic [W:0] a,
  input  logic [W:0] b,
  input  logic       sub,
  output logic [W:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/fraction_multiplier_n.sv
// Signed Q1.(W-1) x Q1.(W-1) add-and-shift multiplier, one bit per clock.
// Ports: CLK, RST_N (async low), St, Mplier, Mcand in; Product, Done,
// Busy, Ovf out; ProductRnd out only when FRAC_MUL_ROUND_EN is defined.
module fraction_multiplier_n
  import frac_mul_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           St,
  input  logic [W-1:0]   Mplier,
  input  logic [W-1:0]   Mcand,
  output logic [2*W-2:0] Product,
  output logic           Done,
  output logic           Busy,
  output logic           Ovf
`ifdef FRAC_MUL_ROUND_EN
  ,
  output logic [W-1:0]   ProductRnd
`endif
);

  localparam int PW = 2 * W - 1;
  localparam int CW = cnt_w(W);

  localparam logic [PW-1:0] SAT = PW'(sat_const(W));
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_e        state_q, state_d;
  logic [W:0]    a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovp_q, ovp_d;
  logic [PW-1:0] prod_q, prod_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          last;
  logic [W:0]    sum;
  logic [W:0]    acc;
  logic [W:0]    a_sh;
  logic [W-1:0]  b_sh;

  assign last = (cnt_q == LAST);

  // Last step weights the multiplier sign bit negatively.
  frac_mul_addsub #(.W(W)) u_addsub (
    .a   (a_q),
    .b   ({c_q[W-1], c_q}),
    .sub (last),
    .y   (sum)
  );

  assign acc  = b_q[0] ? sum : a_q;
  assign a_sh = {acc[W], acc[W:1]};
  assign b_sh = {acc[0], b_q[W-1:1]};

`ifdef FRAC_MUL_ROUND_EN
  logic [W-1:0] rnd_q, rnd_d;
  logic [W-1:0] rnd_top;
  logic         rnd_bit;

  assign rnd_top = prod_d[PW-1:W-1];
  assign rnd_bit = prod_d[W-2];

  always_comb begin
    rnd_d = rnd_q;
    if (state_q == RUN && last) begin
      // Positive maximum plus one would wrap negative; hold at max.
      if (rnd_bit && rnd_top == {1'b0, {(W-1){1'b1}}})
        rnd_d = rnd_top;
      else
        rnd_d = rnd_top + W'(rnd_bit);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rnd_q <= '0;
    else        rnd_q <= rnd_d;
  end

  assign ProductRnd = rnd_q;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovp_d   = ovp_q;
    prod_d  = prod_q;
    ovf_d   = ovf_q;
    // Status flags trail the state by one cycle.
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
    unique case (state_q)
      IDLE: begin
        if (St) begin
          a_d     = '0;
          b_d     = Mplier;
          c_d     = Mcand;
          cnt_d   = '0;
          ovp_d   = (Mplier == MIN_NEG) && (Mcand == MIN_NEG);
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_sh;
        b_d   = b_sh;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          // Drop the redundant top sign bit of the 2W-bit result.
          prod_d  = ovp_q ? SAT : {a_sh[W-2:0], b_sh};
          ovf_d   = ovp_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovp_q   <= 1'b0;
      prod_q  <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovp_q   <= ovp_d;
      prod_q  <= prod_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Product = prod_q;
  assign Ovf     = ovf_q;
  assign Busy    = busy_q;
  assign Done    = done_q;

endmodule
